// File: rtl/regfile_wr_dec.sv
// Registered write-enable decoder for the register file write port.
// Stages one write (index + enable), emits a one-hot enable vector and read-port forwarding flags.
module regfile_wr_dec #(
  parameter int unsigned SEL_W    = 5,
  parameter int unsigned ZERO_REG = 31
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [SEL_W-1:0]      sel,
  input  logic                  en,
  input  logic                  stall,
  input  logic                  flush,
  input  logic [SEL_W-1:0]      rd_a,
  input  logic [SEL_W-1:0]      rd_b,
  output logic [(2**SEL_W)-1:0] out,
  output logic                  out_valid,
  output logic                  zero_hit,
  output logic                  fwd_a,
  output logic                  fwd_b
);

  localparam int unsigned      OUT_N    = 2**SEL_W;
  // An out-of-range ZERO_REG can never match a legal index, so suppression is disabled.
  localparam bit               ZERO_EN  = (ZERO_REG < OUT_N);
  localparam logic [SEL_W-1:0] ZERO_IDX = ZERO_EN ? ZERO_REG[SEL_W-1:0] : '0;

  logic [SEL_W-1:0] s_sel_q, s_sel_d;
  logic             s_en_q, s_en_d;
  logic             s_zero_q, s_zero_d;
  logic             sel_is_zero;

  assign sel_is_zero = ZERO_EN && (sel == ZERO_IDX);

  always_comb begin
    s_sel_d  = s_sel_q;
    s_en_d   = s_en_q;
    s_zero_d = s_zero_q;
    if (flush) begin
      s_en_d   = 1'b0;
      s_zero_d = 1'b0;
    end else if (!stall) begin
      s_sel_d  = sel;
      s_en_d   = en & ~sel_is_zero;
      s_zero_d = en & sel_is_zero;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s_sel_q  <= '0;
      s_en_q   <= 1'b0;
      s_zero_q <= 1'b0;
    end else begin
      s_sel_q  <= s_sel_d;
      s_en_q   <= s_en_d;
      s_zero_q <= s_zero_d;
    end
  end

  always_comb begin
    out = '0;
    if (s_en_q) out[s_sel_q] = 1'b1;
  end

  assign out_valid = s_en_q;
  assign zero_hit  = s_zero_q;
  assign fwd_a     = s_en_q && (s_sel_q == rd_a);
  assign fwd_b     = s_en_q && (s_sel_q == rd_b);

endmodule

// File: tb/tb_regfile_wr_dec.sv
// Bench for regfile_wr_dec: two instances (ZERO_REG=31 and out-of-range ZERO_REG=32)
// checked every cycle against an integer model of the staged write, plus literal spot checks.
module tb_regfile_wr_dec;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [4:0]  sel = '0;
  logic        en = 1'b0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic [4:0]  rd_a = '0;
  logic [4:0]  rd_b = '0;

  logic [31:0] out31, out32;
  logic        ov31, ov32, zh31, zh32, fa31, fa32, fb31, fb32;

  int tests = 0;
  int failed = 0;

  always #5 clk = ~clk;

  regfile_wr_dec #(.SEL_W(5), .ZERO_REG(31)) dut (
    .clk(clk), .reset(reset), .sel(sel), .en(en), .stall(stall), .flush(flush),
    .rd_a(rd_a), .rd_b(rd_b), .out(out31), .out_valid(ov31), .zero_hit(zh31),
    .fwd_a(fa31), .fwd_b(fb31)
  );

  regfile_wr_dec #(.SEL_W(5), .ZERO_REG(32)) dut32 (
    .clk(clk), .reset(reset), .sel(sel), .en(en), .stall(stall), .flush(flush),
    .rd_a(rd_a), .rd_b(rd_b), .out(out32), .out_valid(ov32), .zero_hit(zh32),
    .fwd_a(fa32), .fwd_b(fb32)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: the staged write is either "none" (-1) or a register number; zero flag separate.
  int m_idx31 = -1, m_idx32 = -1;
  bit m_zero31 = 0, m_zero32 = 0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_idx31 = -1; m_zero31 = 0;
      m_idx32 = -1; m_zero32 = 0;
    end else if (flush) begin
      m_idx31 = -1; m_zero31 = 0;
      m_idx32 = -1; m_zero32 = 0;
    end else if (!stall) begin
      m_zero31 = en && (int'(sel) == 31);
      m_idx31  = (en && !m_zero31) ? int'(sel) : -1;
      m_zero32 = en && (int'(sel) == 32);
      m_idx32  = (en && !m_zero32) ? int'(sel) : -1;
    end
  end

  function automatic logic [31:0] onehot(input int idx);
    return (idx >= 0) ? (32'h1 << idx) : 32'h0;
  endfunction

  always @(negedge clk) begin
    chk("out_z31",   out31, onehot(m_idx31));
    chk("valid_z31", {31'b0, ov31}, {31'b0, m_idx31 >= 0});
    chk("zhit_z31",  {31'b0, zh31}, {31'b0, m_zero31});
    chk("fwda_z31",  {31'b0, fa31}, {31'b0, m_idx31 >= 0 && m_idx31 == int'(rd_a)});
    chk("fwdb_z31",  {31'b0, fb31}, {31'b0, m_idx31 >= 0 && m_idx31 == int'(rd_b)});
    chk("out_z32",   out32, onehot(m_idx32));
    chk("zhit_z32",  {31'b0, zh32}, {31'b0, m_zero32});
    chk("fwda_z32",  {31'b0, fa32}, {31'b0, m_idx32 >= 0 && m_idx32 == int'(rd_a)});
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    step(); step();
    chk("rst_out", out31, 32'h0);
    reset = 1'b0;

    // write staged, then asynchronous reset mid-cycle
    sel = 5'd3; en = 1'b1;
    step();
    chk("pre_rst_out", out31, 32'h0000_0008);
    en = 1'b0;
    #1 reset = 1'b1;
    #1;
    chk("async_rst_out", out31, 32'h0);
    chk("async_rst_valid", {31'b0, ov31}, 32'h0);
    chk("async_rst_zhit", {31'b0, zh31}, 32'h0);
    step();
    reset = 1'b0;
    step();
    chk("post_rst_out", out31, 32'h0);

    // full sweep 0..30, back-to-back
    for (int s = 0; s <= 30; s++) begin
      sel = 5'(s); en = 1'b1;
      step();
      if (s == 0)  chk("sweep_sel0", out31, 32'h0000_0001);
      if (s == 30) chk("sweep_sel30", out31, 32'h4000_0000);
    end

    // hardwired zero register
    sel = 5'd31; en = 1'b1; rd_a = 5'd31;
    step();
    chk("zr_out", out31, 32'h0);
    chk("zr_valid", {31'b0, ov31}, 32'h0);
    chk("zr_hit", {31'b0, zh31}, 32'h1);
    chk("zr_fwda", {31'b0, fa31}, 32'h0);
    chk("zr32_out", out32, 32'h8000_0000);
    chk("zr32_hit", {31'b0, zh32}, 32'h0);
    chk("zr32_fwda", {31'b0, fa32}, 32'h1);

    // stall then flush+stall
    sel = 5'd7; en = 1'b1; rd_a = 5'd0;
    step();
    stall = 1'b1; sel = 5'd9;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("stall_hold", out31, 32'h0000_0080);
    end
    flush = 1'b1;
    step();
    chk("flush_out", out31, 32'h0);
    flush = 1'b0; stall = 1'b0;
    step();
    chk("after_flush_load", out31, 32'h0000_0200);

    // forwarding
    sel = 5'd12; en = 1'b1;
    step();
    stall = 1'b1; en = 1'b0;
    rd_a = 5'd12; rd_b = 5'd13;
    #1;
    chk("fwd_a_hit", {31'b0, fa31}, 32'h1);
    chk("fwd_b_miss", {31'b0, fb31}, 32'h0);
    rd_b = 5'd12;
    #1;
    chk("fwd_b_hit", {31'b0, fb31}, 32'h1);
    flush = 1'b1;
    step();
    chk("fwd_a_flushed", {31'b0, fa31}, 32'h0);
    chk("fwd_b_flushed", {31'b0, fb31}, 32'h0);
    flush = 1'b0; stall = 1'b0;

    // bubble
    sel = 5'd5; en = 1'b0; rd_a = 5'd5;
    step();
    chk("bubble_out", out31, 32'h0);
    chk("bubble_valid", {31'b0, ov31}, 32'h0);
    chk("bubble_fwda", {31'b0, fa31}, 32'h0);
    chk("bubble_zhit", {31'b0, zh31}, 32'h0);

    // reset during stall, then normal load
    sel = 5'd4; en = 1'b1;
    step();
    stall = 1'b1;
    reset = 1'b1;
    #1;
    chk("rst_in_stall", out31, 32'h0);
    step();
    reset = 1'b0; stall = 1'b0; sel = 5'd6;
    step();
    chk("load_after_rst", out31, 32'h0000_0040);

    step();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
